// File: rtl/pwm_button_conditioner_pkg.sv
// Shared types and default timing for the PWM button conditioner.
package pwm_button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;
  localparam int DEF_CNT_W           = 28;

endpackage

// File: rtl/button_debounce_channel.sv
// One button: 2-flop synchroniser, debounce/auto-repeat FSM and registered pulse.
module button_debounce_channel
  import pwm_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_held
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       r_sync;
  logic             w_s;
  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_held, w_held_nxt;
  logic             r_pulse, w_pulse_nxt;

  // Saturating increment: a counter parked in HELD with repeat disabled must not wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_s = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= w_held_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = sat_inc(r_cnt);
    w_held_nxt  = r_held;
    w_pulse_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt  = '0;
        w_held_nxt = 1'b0;
        if (w_s) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b1;
          w_pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        w_held_nxt = 1'b1;
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (REPEAT_EN && (r_cnt >= DLY_LAST)) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end
      end
      REPEAT: begin
        w_held_nxt = 1'b1;
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= RATE_LAST) begin
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high returns to HELD silently; the press was already reported.
        if (w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule

// File: rtl/pwm_button_conditioner.sv
// Two debounced button channels feeding mutually exclusive duty inc/dec requests.
module pwm_button_conditioner
  import pwm_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic duty_inc,
  output logic duty_dec,
  output logic inc_held,
  output logic dec_held
);

  logic w_inc_pulse;
  logic w_dec_pulse;

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (REPEAT_EN),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .CNT_W          (CNT_W)
  ) u_inc (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (increase_duty),
    .o_pulse(w_inc_pulse),
    .o_held (inc_held)
  );

  button_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (REPEAT_EN),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE),
    .CNT_W          (CNT_W)
  ) u_dec (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn  (decrease_duty),
    .o_pulse(w_dec_pulse),
    .o_held (dec_held)
  );

  // Coincident requests cancel each other; neither is replayed later.
  assign duty_inc = w_inc_pulse & ~w_dec_pulse;
  assign duty_dec = w_dec_pulse & ~w_inc_pulse;

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed bench for pwm_button_conditioner with a per-cycle pulse scoreboard.
module tb_pwm_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic increase_duty;
  logic decrease_duty;
  logic duty_inc;
  logic duty_dec;
  logic inc_held;
  logic dec_held;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int inc_q[$];
  int dec_q[$];
  bit mon_en = 1'b0;

  pwm_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .duty_inc     (duty_inc),
    .duty_dec     (duty_dec),
    .inc_held     (inc_held),
    .dec_held     (dec_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every cycle, each pulse output must be 1 exactly when its queue head names this cycle.
  always @(negedge clk) begin
    logic exp_inc, exp_dec;
    if (mon_en) begin
      exp_inc = 1'b0;
      exp_dec = 1'b0;
      if (inc_q.size() > 0 && inc_q[0] == cyc) begin
        exp_inc = 1'b1;
        void'(inc_q.pop_front());
      end
      if (dec_q.size() > 0 && dec_q[0] == cyc) begin
        exp_dec = 1'b1;
        void'(dec_q.pop_front());
      end
      tests++;
      assert (duty_inc === exp_inc) else begin
        fails++;
        $error("FAIL duty_inc@%0d: observed %b expected %b", cyc, duty_inc, exp_inc);
      end
      tests++;
      assert (duty_dec === exp_dec) else begin
        fails++;
        $error("FAIL duty_dec@%0d: observed %b expected %b", cyc, duty_dec, exp_dec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s@%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int e;
    int f;
    rst_n = 1'b0;
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    check("reset_duty_inc", duty_inc, 1'b0);
    check("reset_duty_dec", duty_dec, 1'b0);
    check("reset_inc_held", inc_held, 1'b0);
    check("reset_dec_held", dec_held, 1'b0);
    mon_en = 1'b1;

    // Clean press: high for cycles 0-9.
    step();
    e = cyc;
    increase_duty = 1'b1;
    inc_q.push_back(e + 7);
    goto(e + 6);  check("clean_held_pre", inc_held, 1'b0);
    goto(e + 7);  check("clean_held_rise", inc_held, 1'b1);
    goto(e + 10); increase_duty = 1'b0;
    goto(e + 16); check("clean_held_hold", inc_held, 1'b1);
    goto(e + 17); check("clean_held_fall", inc_held, 1'b0);
    goto(e + 20);

    // Press bounce: high runs of 1, 2 and 3 cycles separated by single lows.
    e = cyc;
    for (int i = 0; i < 30; i++) begin
      int ph;
      goto(e + i);
      ph = i % 9;
      increase_duty = (ph != 1 && ph != 4 && ph != 8);
      check("bounce_held", inc_held, 1'b0);
    end
    increase_duty = 1'b0;
    goto(e + 40);
    check("bounce_held_end", inc_held, 1'b0);

    // Auto-repeat on decrease: high for cycles 0-49.
    e = cyc;
    decrease_duty = 1'b1;
    dec_q.push_back(e + 7);
    dec_q.push_back(e + 27);
    dec_q.push_back(e + 35);
    dec_q.push_back(e + 43);
    dec_q.push_back(e + 51);
    goto(e + 30); check("repeat_held", dec_held, 1'b1);
    goto(e + 50); decrease_duty = 1'b0;
    goto(e + 56); check("repeat_held_hold", dec_held, 1'b1);
    goto(e + 57); check("repeat_held_fall", dec_held, 1'b0);
    goto(e + 70);

    // Simultaneous press: both held 12 cycles, pulses cancel.
    e = cyc;
    increase_duty = 1'b1;
    decrease_duty = 1'b1;
    goto(e + 6);
    check("simul_inc_held_pre", inc_held, 1'b0);
    check("simul_dec_held_pre", dec_held, 1'b0);
    goto(e + 7);
    check("simul_inc_held", inc_held, 1'b1);
    check("simul_dec_held", dec_held, 1'b1);
    goto(e + 12);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    goto(e + 25);
    check("simul_inc_held_end", inc_held, 1'b0);
    check("simul_dec_held_end", dec_held, 1'b0);

    // Release bounce: low 10-11, glitch high 12-13, low afterwards.
    e = cyc;
    increase_duty = 1'b1;
    inc_q.push_back(e + 7);
    for (int c = 7; c <= 20; c++) begin
      goto(e + c);
      if (c == 10) increase_duty = 1'b0;
      if (c == 12) increase_duty = 1'b1;
      if (c == 14) increase_duty = 1'b0;
      check("relbounce_held", inc_held, 1'b1);
    end
    goto(e + 21);
    check("relbounce_held_fall", inc_held, 1'b0);
    goto(e + 25);

    // Reset asserted in the pulse cycle of a press, then released with the button held.
    e = cyc;
    increase_duty = 1'b1;
    goto(e + 7);
    check("rst_pre_pulse", duty_inc, 1'b1);
    check("rst_pre_held", inc_held, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_duty_inc", duty_inc, 1'b0);
    check("rst_duty_dec", duty_dec, 1'b0);
    check("rst_inc_held", inc_held, 1'b0);
    check("rst_dec_held", dec_held, 1'b0);
    step();
    step();
    check("rst_hold_inc", duty_inc, 1'b0);
    f = cyc;
    rst_n = 1'b1;
    inc_q.push_back(f + 7);
    goto(f + 6);  check("rst_requal_pre", inc_held, 1'b0);
    goto(f + 7);  check("rst_requal_held", inc_held, 1'b1);
    goto(f + 10); increase_duty = 1'b0;
    goto(f + 25);
    check("rst_final_held", inc_held, 1'b0);

    tests++;
    assert (inc_q.size() == 0 && dec_q.size() == 0) else begin
      fails++;
      $error("FAIL pending_pulses: observed %0d/%0d expected 0/0", inc_q.size(), dec_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
